// File: rtl/xosera_pkg.sv
// Shared bus constants and state type for the 68k register bus front-end.
package xv;
    localparam logic CS_ENABLED     = 1'b0;   // bus_cs_n level that selects the block
    localparam logic RnW_READ       = 1'b1;   // bus_rd_nwr level for a read cycle
    localparam logic DTACK_ASSERTED = 1'b0;   // DTACK is active low on the 68k bus

    typedef enum logic [2:0] {
        IDLE,
        STROBE,
        WAIT_RD,
        DTACK,
        DONE
    } bus_state_t;
endpackage

// File: rtl/sync_ff_chain.sv
// Generic multi-flop synchronizer with async reset to a chosen idle level.
// Kept standalone so the serial receive input can reuse it.
module sync_ff_chain #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    // shift the async input one stage deeper each clock
    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d_i};
    end

    // synchronizer flops, preset to the idle level on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain_q <= {STAGES{RESET_VAL}};
        else        chain_q <= chain_d;
    end

    assign q_o = chain_q[STAGES-1];
endmodule

// File: rtl/m68k_bus_sync.sv
// 68k register bus front-end: synchronizes chip select, latches the access,
// issues one read/write strobe per select and runs the DTACK handshake.
module m68k_bus_sync
    import xv::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int RD_TIMEOUT  = 15
) (
    input  logic       clk,
    input  logic       reset_n_i,
    input  logic       bus_cs_n_i,
    input  logic       bus_rd_nwr_i,
    input  logic       bus_bytesel_i,
    input  logic [3:0] bus_reg_num_i,
    input  logic [7:0] bus_data_i,
    input  logic       rd_ready_i,
    output logic [3:0] reg_num_o,
    output logic       bytesel_o,
    output logic [7:0] data_o,
    output logic       write_strobe_o,
    output logic       read_strobe_o,
    output logic       bus_dtack_o,
    output logic       rd_timeout_o
);
    localparam logic [7:0] TIMEOUT_CNT = 8'(RD_TIMEOUT);

    logic       cs_s;
    logic       cs_active;
    bus_state_t state_q, state_d;
    logic [3:0] reg_num_q, reg_num_d;
    logic       bytesel_q, bytesel_d;
    logic [7:0] data_q, data_d;
    logic       rd_nwr_q, rd_nwr_d;
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;

    // chain presets to deselected so reset never looks like an access
    sync_ff_chain #(
        .STAGES   (SYNC_STAGES),
        .RESET_VAL(1'b1)
    ) u_cs_sync (
        .clk  (clk),
        .rst_n(reset_n_i),
        .d_i  (bus_cs_n_i),
        .q_o  (cs_s)
    );

    assign cs_active = (cs_s == CS_ENABLED);

    // next-state and datapath latch decisions; address/data pins are
    // already stable when CS arrives, so they are sampled raw
    always_comb begin
        state_d   = state_q;
        reg_num_d = reg_num_q;
        bytesel_d = bytesel_q;
        data_d    = data_q;
        rd_nwr_d  = rd_nwr_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (cs_active) begin
                    reg_num_d = bus_reg_num_i;
                    bytesel_d = bus_bytesel_i;
                    data_d    = bus_data_i;
                    rd_nwr_d  = bus_rd_nwr_i;
                    state_d   = STROBE;
                end
            end
            STROBE: begin
                if (!cs_active)                 state_d = DONE;
                else if (rd_nwr_q == RnW_READ) begin
                    cnt_d   = 8'd0;
                    state_d = WAIT_RD;
                end
                else                            state_d = DTACK;
            end
            WAIT_RD: begin
                // cnt_d is the number of WAIT_RD cycles including this one
                cnt_d = cnt_q + 8'd1;
                if (!cs_active)         state_d = DONE;
                else if (rd_ready_i)    state_d = DTACK;
                else if (cnt_d == TIMEOUT_CNT) begin
                    timeout_d = 1'b1;
                    state_d   = DTACK;
                end
            end
            DTACK: begin
                if (!cs_active) state_d = DONE;
            end
            DONE:    state_d = IDLE;   // forced deselected gap between accesses
            default: state_d = IDLE;
        endcase
    end

    // state and latched access registers
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            reg_num_q <= 4'd0;
            bytesel_q <= 1'b0;
            data_q    <= 8'd0;
            rd_nwr_q  <= 1'b0;
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            reg_num_q <= reg_num_d;
            bytesel_q <= bytesel_d;
            data_q    <= data_d;
            rd_nwr_q  <= rd_nwr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // outputs decode straight from registers so reset clears them at once
    assign reg_num_o      = reg_num_q;
    assign bytesel_o      = bytesel_q;
    assign data_o         = data_q;
    assign write_strobe_o = (state_q == STROBE) && (rd_nwr_q != RnW_READ);
    assign read_strobe_o  = (state_q == STROBE) && (rd_nwr_q == RnW_READ);
    assign bus_dtack_o    = (state_q == DTACK) ? DTACK_ASSERTED : ~DTACK_ASSERTED;
    assign rd_timeout_o   = timeout_q;
endmodule
